// File: rtl/kernel_pkg.sv
// Shared definitions for the mini_kernel core: instruction field layout,
// write-source and ALU encodings, FSM states and an instruction decoder.
package kernel_pkg;

  localparam int J_BIT     = 31;
  localparam int B_BIT     = 30;
  localparam int WE_BIT    = 29;
  localparam int WS_MSB    = 28;
  localparam int WS_LSB    = 27;
  localparam int ALU_MSB   = 26;
  localparam int ALU_LSB   = 23;
  localparam int RA1_MSB   = 22;
  localparam int RA1_LSB   = 18;
  localparam int RA2_MSB   = 17;
  localparam int RA2_LSB   = 13;
  localparam int WA_MSB    = 12;
  localparam int WA_LSB    = 8;
  localparam int CONST_MSB = 7;
  localparam int CONST_LSB = 0;

  typedef enum logic [1:0] {
    WS_CONST  = 2'b00,
    WS_IN_RAW = 2'b01,
    WS_ALU    = 2'b10,
    WS_IN_HS  = 2'b11
  } ws_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLTS = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_LTS  = 4'd12,
    ALU_GES  = 4'd13,
    ALU_LTU  = 4'd14,
    ALU_GEU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  typedef struct packed {
    logic       j;
    logic       b;
    logic       we;
    ws_e        ws;
    alu_op_e    alu_op;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [31:0] w);
    instr_t d;
    d.j      = w[J_BIT];
    d.b      = w[B_BIT];
    d.we     = w[WE_BIT];
    d.ws     = ws_e'(w[WS_MSB:WS_LSB]);
    d.alu_op = alu_op_e'(w[ALU_MSB:ALU_LSB]);
    d.ra1    = w[RA1_MSB:RA1_LSB];
    d.ra2    = w[RA2_MSB:RA2_LSB];
    d.wa     = w[WA_MSB:WA_LSB];
    d.imm    = w[CONST_MSB:CONST_LSB];
    return d;
  endfunction

  // An unconditional jump by zero would spin forever, so it doubles as halt.
  function automatic logic is_halt(input instr_t i);
    return i.j && (i.imm == 8'd0);
  endfunction

endpackage

// File: rtl/kernel_rf.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Index 0 and indices beyond REG_NUM read as zero and ignore writes.
module kernel_rf #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [4:0]        ra1_i,
  input  logic [4:0]        ra2_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o,
  input  logic              we_i,
  input  logic [4:0]        wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  localparam int IW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [XLEN-1:0] mem_q [REG_NUM];
  logic [XLEN-1:0] mem_d [REG_NUM];

  function automatic logic live_idx(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < REG_NUM);
  endfunction

  assign rd1_o = live_idx(ra1_i) ? mem_q[ra1_i[IW-1:0]] : '0;
  assign rd2_o = live_idx(ra2_i) ? mem_q[ra2_i[IW-1:0]] : '0;

  always_comb begin
    mem_d = mem_q;
    if (we_i && live_idx(wa_i)) begin
      mem_d[wa_i[IW-1:0]] = wd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/miriscv_alu.sv
// Combinational ALU: arithmetic/logic results plus a comparison flag used
// for conditional branches.
module miriscv_alu
  import kernel_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           operator_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  output logic [XLEN-1:0]   result_o,
  output logic              comparison_result_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = operand_b_i[SHW-1:0];

  always_comb begin
    result_o            = '0;
    comparison_result_o = 1'b0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt;
      ALU_SRL:  result_o = operand_a_i >> shamt;
      ALU_SRA:  result_o = $signed(operand_a_i) >>> shamt;
      ALU_SLTS: result_o = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      ALU_EQ:   comparison_result_o = (operand_a_i == operand_b_i);
      ALU_NE:   comparison_result_o = (operand_a_i != operand_b_i);
      ALU_LTS:  comparison_result_o = ($signed(operand_a_i) < $signed(operand_b_i));
      ALU_GES:  comparison_result_o = ($signed(operand_a_i) >= $signed(operand_b_i));
      ALU_LTU:  comparison_result_o = (operand_a_i < operand_b_i);
      ALU_GEU:  comparison_result_o = (operand_a_i >= operand_b_i);
      default:  result_o = '0;
    endcase
    if (operator_i >= ALU_EQ) begin
      result_o = {{(XLEN-1){1'b0}}, comparison_result_o};
    end
  end

endmodule

// File: rtl/mini_kernel.sv
// Two-cycle-per-instruction teaching core: fetch from a combinational ROM,
// execute one register-transfer, optional blocking input handshake.
module mini_kernel
  import kernel_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int IMEM_AW = 10,
  parameter int IN_W    = 10,
  parameter int OUT_REG = 1
) (
  input  logic               clk_i,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  input  logic [IN_W-1:0]    in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [XLEN-1:0]    out_data_o,
  output logic               out_valid_o,
  output logic               halted_o
);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [XLEN-1:0]    out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  instr_t             instr;
  logic [XLEN-1:0]    rd1, rd2, alu_res, wdata, imm_sext, in_zext;
  logic               alu_flag, wr_req, rf_we;
  logic [IMEM_AW-1:0] pc_offset;

  assign instr     = decode(ir_q);
  assign imm_sext  = XLEN'($signed(instr.imm));
  assign in_zext   = XLEN'(in_data_i);
  assign pc_offset = IMEM_AW'($signed(instr.imm));

  kernel_rf #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM)
  ) u_rf (
    .clk_i (clk_i),
    .reset (reset),
    .ra1_i (instr.ra1),
    .ra2_i (instr.ra2),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (rf_we),
    .wa_i  (instr.wa),
    .wd_i  (wdata)
  );

  miriscv_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .operator_i          (instr.alu_op),
    .operand_a_i         (rd1),
    .operand_b_i         (rd2),
    .result_o            (alu_res),
    .comparison_result_o (alu_flag)
  );

  // In WAIT_IN the held instruction still has WS=11, so this mux also
  // supplies the handshaked value.
  always_comb begin
    wdata = in_zext;
    case (instr.ws)
      WS_CONST:  wdata = imm_sext;
      WS_IN_RAW: wdata = in_zext;
      WS_ALU:    wdata = alu_res;
      default:   wdata = in_zext;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wr_req  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_rdata_i;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt(instr)) begin
          state_d = ST_HALT;
        end else if (instr.we && (instr.ws == WS_IN_HS)) begin
          state_d = ST_WAIT_IN;
        end else begin
          wr_req  = instr.we;
          state_d = ST_FETCH;
          if (instr.j || (instr.b && alu_flag)) begin
            pc_d = pc_q + pc_offset;
          end else begin
            pc_d = pc_q + IMEM_AW'(1);
          end
        end
      end
      ST_WAIT_IN: begin
        if (in_valid_i) begin
          wr_req  = 1'b1;
          pc_d    = pc_q + IMEM_AW'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Only writes that actually land in the register file may pulse the output.
  always_comb begin
    rf_we       = wr_req && (instr.wa != 5'd0) && (int'(instr.wa) < REG_NUM);
    out_valid_d = rf_we && (instr.wa == 5'(OUT_REG));
    out_data_d  = out_valid_d ? wdata : out_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign in_ready_o  = (state_q == ST_WAIT_IN);
  assign halted_o    = (state_q == ST_HALT);
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mini_kernel.sv
// Self-checking bench for mini_kernel: single-instruction vector table,
// hand-written multi-cycle sequences and random programs vs an ISA model.
module tb_mini_kernel;
  import kernel_pkg::*;

  localparam logic [31:0] HALT_W = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  imemAddr;
  logic [31:0] imemRdata;
  logic [9:0]  inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] outData;
  logic        outValid;
  logic        halted;

  logic [31:0] rom [1024];
  int checks = 0;
  int errors = 0;
  logic [31:0] expOut [$];
  logic [31:0] gotOut [$];

  mini_kernel #(
    .XLEN(32), .REG_NUM(32), .IMEM_AW(10), .IN_W(10), .OUT_REG(1)
  ) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .imem_addr_o  (imemAddr),
    .imem_rdata_i (imemRdata),
    .in_data_i    (inData),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .out_data_o   (outData),
    .out_valid_o  (outValid),
    .halted_o     (halted)
  );

  assign imemRdata = rom[imemAddr];

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] instr;
    logic [9:0]  inVal;
    logic        expValid;
    logic [31:0] expData;
    logic [9:0]  expPc;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] mk(input logic j, input logic b, input logic we,
                                     input logic [1:0] ws, input logic [3:0] op,
                                     input logic [4:0] ra1, input logic [4:0] ra2,
                                     input logic [4:0] wa, input logic [7:0] c);
    return {j, b, we, ws, op, ra1, ra2, wa, c};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 1024; i++) rom[i] = HALT_W;
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    reset = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    reset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Runs one table entry: x4=a, x5=b, then the instruction under test at PC 2.
  task automatic applyStimulus(input vec_t v);
    clearRom();
    rom[0] = mk(0, 0, 1, 2'b00, 4'd0, 5'd0, 5'd0, 5'd4, v.a);
    rom[1] = mk(0, 0, 1, 2'b00, 4'd0, 5'd0, 5'd0, 5'd5, v.b);
    rom[2] = v.instr;
    inValid = 1'b0;
    inData  = v.inVal;
    resetDut();
    runCycles(6);
    checkOutput({v.name, " out_valid"}, 32'(outValid), 32'(v.expValid));
    checkOutput({v.name, " out_data"}, outData, v.expData);
    checkOutput({v.name, " next_pc"}, 32'(imemAddr), 32'(v.expPc));
  endtask

  function automatic void aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic flag);
    res  = 32'd0;
    flag = 1'b0;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a ^ b;
      4'd3:  res = a | b;
      4'd4:  res = a & b;
      4'd5:  res = a << b[4:0];
      4'd6:  res = a >> b[4:0];
      4'd7:  res = $signed(a) >>> b[4:0];
      4'd8:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      4'd10: flag = (a == b);
      4'd11: flag = (a != b);
      4'd12: flag = ($signed(a) < $signed(b));
      4'd13: flag = ($signed(a) >= $signed(b));
      4'd14: flag = (a < b);
      default: flag = (a >= b);
    endcase
    if (op >= 4'd10) res = flag ? 32'd1 : 32'd0;
  endfunction

  // Instruction-level model: returns the cycle on which halted_o first reads 1,
  // fills expOut with every value written to x1.
  task automatic runModel(input logic [9:0] inVal, output int cyc);
    logic [31:0] regs [32];
    logic [31:0] w, val, res, imm;
    logic flag;
    int pc;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    expOut.delete();
    pc  = 0;
    cyc = 0;
    for (int step = 0; step < 500; step++) begin
      w   = rom[pc];
      imm = {{24{w[7]}}, w[7:0]};
      if (w[31] && w[7:0] == 8'd0) begin
        cyc += 2;
        return;
      end
      aluModel(w[26:23], regs[w[22:18]], regs[w[17:13]], res, flag);
      if (w[29] && w[28:27] == 2'b11) begin
        val = {22'd0, inVal};
        if (w[12:8] != 5'd0) begin
          regs[w[12:8]] = val;
          if (w[12:8] == 5'd1) expOut.push_back(val);
        end
        pc = (pc + 1) % 1024;
        cyc += 3;
      end else begin
        case (w[28:27])
          2'b00:   val = imm;
          2'b10:   val = res;
          default: val = {22'd0, inVal};
        endcase
        if (w[29] && w[12:8] != 5'd0) begin
          regs[w[12:8]] = val;
          if (w[12:8] == 5'd1) expOut.push_back(val);
        end
        if (w[31] || (w[30] && flag)) pc = ((pc + int'($signed(w[7:0]))) % 1024 + 1024) % 1024;
        else pc = (pc + 1) % 1024;
        cyc += 2;
      end
    end
    cyc = -1;
  endtask

  // Runs the loaded program until halted, recording every out_valid pulse.
  task automatic runDut(input int budget, output int haltCyc);
    gotOut.delete();
    haltCyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (outValid) gotOut.push_back(outData);
      if (halted) begin
        haltCyc = k;
        break;
      end
    end
  endtask

  initial begin
    int haltCyc, modelCyc, readyCnt, pulses;
    logic [31:0] pulseData;
    logic [9:0]  pulseAddr;
    logic sent, dropValid;

    vecs[0]  = '{"add",   8'd5,   8'd3,  mk(0,0,1,2'b10,ALU_ADD, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'd8,          10'd3};
    vecs[1]  = '{"sub",   8'd3,   8'd5,  mk(0,0,1,2'b10,ALU_SUB, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'hFFFF_FFFE,  10'd3};
    vecs[2]  = '{"xor",   8'h0F,  8'h33, mk(0,0,1,2'b10,ALU_XOR, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'h3C,         10'd3};
    vecs[3]  = '{"sll",   8'd1,   8'd4,  mk(0,0,1,2'b10,ALU_SLL, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'd16,         10'd3};
    vecs[4]  = '{"sra",   8'h80,  8'd4,  mk(0,0,1,2'b10,ALU_SRA, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'hFFFF_FFF8,  10'd3};
    vecs[5]  = '{"srl",   8'h80,  8'd28, mk(0,0,1,2'b10,ALU_SRL, 5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'h0000_000F,  10'd3};
    vecs[6]  = '{"sltu",  8'hFF,  8'd1,  mk(0,0,1,2'b10,ALU_SLTU,5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'd0,          10'd3};
    vecs[7]  = '{"slts",  8'hFF,  8'd1,  mk(0,0,1,2'b10,ALU_SLTS,5'd4,5'd5,5'd1,8'd0),  10'd0,    1'b1, 32'd1,          10'd3};
    vecs[8]  = '{"const", 8'd0,   8'd0,  mk(0,0,1,2'b00,ALU_ADD, 5'd0,5'd0,5'd1,8'h80), 10'd0,    1'b1, 32'hFFFF_FF80,  10'd3};
    vecs[9]  = '{"x0wr",  8'd0,   8'd0,  mk(0,0,1,2'b00,ALU_ADD, 5'd0,5'd0,5'd0,8'h80), 10'd0,    1'b0, 32'd0,          10'd3};
    vecs[10] = '{"rawin", 8'd0,   8'd0,  mk(0,0,1,2'b01,ALU_ADD, 5'd0,5'd0,5'd1,8'd0),  10'h3FF,  1'b1, 32'h3FF,        10'd3};
    vecs[11] = '{"beq_t", 8'd7,   8'd7,  mk(0,1,0,2'b10,ALU_EQ,  5'd4,5'd5,5'd0,8'hFE), 10'd0,    1'b0, 32'd0,          10'd0};
    vecs[12] = '{"beq_n", 8'd7,   8'd8,  mk(0,1,0,2'b10,ALU_EQ,  5'd4,5'd5,5'd0,8'hFE), 10'd0,    1'b0, 32'd0,          10'd3};
    vecs[13] = '{"jb",    8'd7,   8'd8,  mk(1,1,0,2'b10,ALU_EQ,  5'd4,5'd5,5'd0,8'd3),  10'd0,    1'b0, 32'd0,          10'd5};
    vecs[14] = '{"jwr",   8'd0,   8'd0,  mk(1,0,1,2'b00,ALU_ADD, 5'd0,5'd0,5'd1,8'd2),  10'd0,    1'b1, 32'd2,          10'd4};
    vecs[15] = '{"bne",   8'd7,   8'd8,  mk(0,1,0,2'b10,ALU_NE,  5'd4,5'd5,5'd0,8'd2),  10'd0,    1'b0, 32'd0,          10'd4};

    // Reset state
    clearRom();
    resetDut();
    checkOutput("rst pc", 32'(imemAddr), 32'd0);
    checkOutput("rst out_data", outData, 32'd0);
    checkOutput("rst out_valid", 32'(outValid), 32'd0);
    checkOutput("rst in_ready", 32'(inReady), 32'd0);
    checkOutput("rst halted", 32'(halted), 32'd0);

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

    // Small program: x1=5; x2=3; x3=x1+x2; x1=x3; halt
    clearRom();
    rom[0] = mk(0,0,1,2'b00,ALU_ADD,5'd0,5'd0,5'd1,8'd5);
    rom[1] = mk(0,0,1,2'b00,ALU_ADD,5'd0,5'd0,5'd2,8'd3);
    rom[2] = mk(0,0,1,2'b10,ALU_ADD,5'd1,5'd2,5'd3,8'd0);
    rom[3] = mk(0,0,1,2'b10,ALU_ADD,5'd3,5'd0,5'd1,8'd0);
    resetDut();
    runDut(50, haltCyc);
    checkOutput("prog halt cycle", 32'(haltCyc), 32'd10);
    checkOutput("prog pulses", 32'(gotOut.size()), 32'd2);
    if (gotOut.size() == 2) begin
      checkOutput("prog out0", gotOut[0], 32'd5);
      checkOutput("prog out1", gotOut[1], 32'd8);
    end
    checkOutput("halt pc held", 32'(imemAddr), 32'd4);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      runCycles(1);
      if (outValid || inReady || !halted) pulses++;
    end
    checkOutput("halt sticky", 32'(pulses), 32'd0);

    // Input handshake with 20 idle cycles
    clearRom();
    rom[0] = mk(0,0,1,2'b11,ALU_ADD,5'd0,5'd0,5'd1,8'd0);
    inValid = 1'b0;
    inData  = 10'd0;
    resetDut();
    readyCnt = 0; pulses = 0; sent = 1'b0; dropValid = 1'b0;
    pulseData = '0; pulseAddr = '0;
    for (int k = 0; k < 30; k++) begin
      runCycles(1);
      if (dropValid) begin inValid = 1'b0; dropValid = 1'b0; end
      if (outValid) begin pulses++; pulseData = outData; pulseAddr = imemAddr; end
      if (inReady) readyCnt++;
      if (readyCnt == 21 && !sent) begin
        inValid = 1'b1; inData = 10'h3FF; sent = 1'b1; dropValid = 1'b1;
      end
    end
    checkOutput("hs ready cycles", 32'(readyCnt), 32'd21);
    checkOutput("hs pulses", 32'(pulses), 32'd1);
    checkOutput("hs out_data", pulseData, 32'h3FF);
    checkOutput("hs pc", 32'(pulseAddr), 32'd1);

    // PC wrap in both directions
    clearRom();
    rom[0]    = mk(1,0,0,2'b00,ALU_ADD,5'd0,5'd0,5'd0,8'hFF);
    rom[1023] = mk(0,0,1,2'b00,ALU_ADD,5'd0,5'd0,5'd1,8'd7);
    resetDut();
    runCycles(2);
    checkOutput("wrap back pc", 32'(imemAddr), 32'd1023);
    runCycles(2);
    checkOutput("wrap fwd pc", 32'(imemAddr), 32'd0);
    checkOutput("wrap out_data", outData, 32'd7);

    // Reset during WAIT_IN with valid high
    clearRom();
    rom[0] = mk(0,0,1,2'b11,ALU_ADD,5'd0,5'd0,5'd1,8'd0);
    inValid = 1'b0;
    resetDut();
    runCycles(3);
    checkOutput("wr wait ready", 32'(inReady), 32'd1);
    inValid = 1'b1; inData = 10'h155; reset = 1'b1;
    runCycles(1);
    checkOutput("wr rst valid", 32'(outValid), 32'd0);
    checkOutput("wr rst ready", 32'(inReady), 32'd0);
    checkOutput("wr rst pc", 32'(imemAddr), 32'd0);
    reset = 1'b0; inValid = 1'b0;
    runCycles(1);
    checkOutput("wr no write", outData, 32'd0);
    runCycles(1);
    checkOutput("wr refetch", 32'(inReady), 32'd1);

    // Random programs against the instruction-level model
    for (int p = 0; p < 20; p++) begin
      logic [9:0] rin;
      clearRom();
      for (int i = 0; i < 12; i++) begin
        logic b;
        logic [7:0] c;
        b = ($urandom % 4) == 0;
        c = b ? 8'($urandom_range(1, 3)) : 8'($urandom % 256);
        rom[i] = mk(1'b0, b, ($urandom % 4) != 0, 2'($urandom % 4), 4'($urandom % 16),
                    5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4), c);
      end
      rin = 10'($urandom);
      runModel(rin, modelCyc);
      inValid = 1'b1;
      inData  = rin;
      resetDut();
      runDut(300, haltCyc);
      checkOutput($sformatf("rand%0d halt cycle", p), 32'(haltCyc), 32'(modelCyc));
      checkOutput($sformatf("rand%0d pulses", p), 32'(gotOut.size()), 32'(expOut.size()));
      for (int i = 0; i < expOut.size() && i < gotOut.size(); i++)
        checkOutput($sformatf("rand%0d out%0d", p, i), gotOut[i], expOut[i]);
    end
    inValid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_kernel.md
MINI_KERNEL -- requirements
Module: mini_kernel

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width (min 8).
REQ-002 SHALL have parameter REG_NUM, default 32, number of registers (2..32); x0 reads zero.
REQ-003 SHALL have parameter IMEM_AW, default 10, instruction word-address width.
REQ-004 SHALL have parameter IN_W, default 10, input port width (IN_W <= XLEN).
REQ-005 SHALL have parameter OUT_REG, default 1, register index mirrored to the output port.
REQ-006 SHALL have port clk_i, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-008 SHALL have port imem_addr_o, output, IMEM_AW, word address into the combinational ROM.
REQ-009 SHALL have port imem_rdata_i, input, 32, instruction word, valid in the same cycle as the address.
REQ-010 SHALL have port in_data_i, input, IN_W, external data (switches or peripheral).
REQ-011 SHALL have port in_valid_i, input, 1, in_data_i valid.
REQ-012 SHALL have port in_ready_o, output, 1, core waiting for input.
REQ-013 SHALL have port out_data_o, output, XLEN, last value written to OUT_REG.
REQ-014 SHALL have port out_valid_o, output, 1, one-cycle pulse on each OUT_REG write.
REQ-015 SHALL have port halted_o, output, 1, core halted.

Function
REQ-016 SHALL decode these instruction fields: [31] J, [30] B, [29] WE, [28:27] WS, [26:23] ALUop, [22:18] RA1, [17:13] RA2, [12:8] WA, [7:0] CONST.
REQ-017 SHALL implement the FSM states FETCH, EXEC, WAIT_IN and HALT; reset enters FETCH.
REQ-018 In FETCH, SHALL drive imem_addr_o = PC, latch imem_rdata_i into IR, and go to EXEC; CPI = 2.
REQ-019 In EXEC, SHALL treat J=1 with CONST=0 as halt: enter HALT with no RF write, set halted_o next cycle, and keep PC unchanged.
REQ-020 In EXEC, SHALL select the write source by WS: 00 sign-extended CONST to XLEN; 01 zero-extended in_data_i, sampled without handshake; 10 ALU result; 11 handshaked input.
REQ-021 In EXEC with WE=1 and WS=11, SHALL enter WAIT_IN with no PC update and no write.
REQ-022 In EXEC, SHALL otherwise write RF[WA] when WE=1, WA!=0 and WA<REG_NUM; all other writes are dropped.
REQ-023 In EXEC, SHALL set the next PC as follows: if J, PC+sext(CONST); else if B and comparison_result=1, PC+sext(CONST); else PC+1.
REQ-024 J SHALL take priority over B.
REQ-025 PC arithmetic SHALL be modulo 2^IMEM_AW, with wrap-around in both directions.
REQ-026 In WAIT_IN, SHALL assert in_ready_o; on in_valid_i=1, SHALL write the zero-extended in_data_i to WA (subject to REQ-022), set PC+1, and return to FETCH.
REQ-027 In WAIT_IN, in_valid_i=0 SHALL leave the core stalled indefinitely.
REQ-028 Reads of index 0 or index >= REG_NUM SHALL return 0.
REQ-029 On a write to OUT_REG, out_data_o SHALL update and out_valid_o SHALL pulse in the following cycle; a dropped write SHALL produce no pulse.
REQ-030 HALT SHALL be sticky until reset; in HALT, in_ready_o=0 and no writes occur.

Reset
REQ-031 On reset, SHALL set PC=0, IR=0, state FETCH, all registers 0, out_data_o=0, out_valid_o=0, in_ready_o=0 and halted_o=0 at the next edge.
REQ-032 Reset in any state, including mid-WAIT_IN with in_valid_i high, SHALL abort the pending write and take priority over every other event.

Structure
REQ-033 Opcode field positions, WS encodings, ALUop values and FSM state encodings SHALL reside in a shared package kernel_pkg.
REQ-034 The register file SHALL be a sub-module kernel_rf (parameters XLEN and REG_NUM; two asynchronous read ports, one synchronous write port).
REQ-035 The existing miriscv_alu SHALL be instantiated unchanged.

Verification
REQ-036 Program "x1=5; x2=3; x3=x1+x2; x1=x3; halt" -> out_data_o=5 then 8, two out_valid_o pulses, halted_o=1 at cycle 10.
REQ-037 Input handshake: WS=11, WA=1, in_valid_i held low for 20 cycles then in_data_i=10'h3FF with valid -> in_ready_o high for 21 cycles, out_data_o=32'h3FF, PC advances by exactly 1.
REQ-038 Branch: beq with x1=x2 and CONST=8'hFE -> PC decrements by 2; with x1!=x2 -> PC+1; J=1 and B=1 together -> jump taken.
REQ-039 Write to x0 with CONST=8'h80 -> x0 still reads 0, no out_valid_o pulse; with OUT_REG=0 and WA=1, x1 reads 32'hFFFFFF80.
REQ-040 PC=2^IMEM_AW-1 with a non-jump instruction -> next fetch address is 0; reset asserted during WAIT_IN with valid high -> no write, PC=0, state FETCH.
